// File: rtl/bitmap_encoder.sv
// -----------------------------------------------------------------------------
// bitmap_encoder
//   Registered 16-to-4 encoder, the inverse of a 4-to-16 decoder. A bitmap is
//   accepted over a valid/ready handshake. The block then emits the index of
//   every set bit, lowest index first, with one beat per output handshake. The
//   final beat of a bitmap is flagged with out_last.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   Z          in   [W-1:0]  input bitmap, sampled on the input handshake
//   in_valid   in   Z is valid
//   in_ready   out  block can accept a bitmap (IDLE, not in reset)
//   A          out  [AW-1:0] index of the current set bit
//   out_valid  out  A is valid (DRAIN, not in reset)
//   out_ready  in   consumer accepts A
//   out_last   out  current beat is the highest set bit of the bitmap
//   count      out  [AW:0]   popcount of the latched bitmap
//   zero_drop  out  one-cycle pulse after an all-zero bitmap is discarded
// -----------------------------------------------------------------------------
module bitmap_encoder #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  Z,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] A,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [AW:0]   count,
    output logic          zero_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    pend_q, pend_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   a_q, a_d;
    logic            last_q, last_d;
    logic            zero_drop_q, zero_drop_d;

    // Index of the lowest set bit. An all-zero vector yields 0.
    function automatic logic [AW-1:0] lowest_index(input logic [W-1:0] v);
        lowest_index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = AW'(i);
        end
    endfunction

    function automatic logic [AW:0] popcount(input logic [W-1:0] v);
        popcount = '0;
        for (int i = 0; i < W; i++) begin
            popcount = popcount + (AW+1)'(v[i]);
        end
    endfunction

    // Next-state logic. The A and out_last values for the next beat are
    // derived from pend_d. They are registered, so they change only on a
    // handshake and stay stable under backpressure.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        pend_d      = pend_q;
        count_d     = count_q;
        zero_drop_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (Z != '0) begin
                        pend_d  = Z;
                        count_d = popcount(Z);
                        state_d = DRAIN;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    // Clear the lowest set bit, which is the one just emitted.
                    pend_d = pend_q & (pend_q - W'(1));
                    if (last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        a_d    = lowest_index(pend_d);
        last_d = (pend_d != '0) && ((pend_d & (pend_d - W'(1))) == '0);
    end

    // NOTE: state registers use non-blocking assignments so that all of them update together on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            count_q     <= '0;
            a_q         <= '0;
            last_q      <= 1'b0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            a_q         <= a_d;
            last_q      <= last_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // The outputs are masked by reset so that they show reset values for the
    // whole time reset is high, including the first reset cycle. Masking also
    // lets in_ready rise in the same cycle that reset is released.
    assign in_ready  = !reset && (state_q == IDLE);
    assign out_valid = !reset && (state_q == DRAIN);
    assign A         = reset ? '0 : a_q;
    assign out_last  = !reset && last_q;
    assign count     = reset ? '0 : count_q;
    assign zero_drop = !reset && zero_drop_q;

endmodule

// File: tb/tb_bitmap_encoder.sv
// -----------------------------------------------------------------------------
// tb_bitmap_encoder
//   Self-checking bench for bitmap_encoder. For each bitmap that is sent, the
//   expected beats go into a queue. A monitor pops them and compares them on
//   every output handshake. The per-scenario tasks check handshake timing,
//   stability, zero-drop and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_bitmap_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Z;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  A;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [4:0]  count;
    logic        zero_drop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic       last;
        logic [4:0] cnt;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;

    bitmap_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .Z         (Z),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor. Inputs change only at posedge+1, so the values seen
    // at the negedge are the ones that take part in the following handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got A=%0d last=%0b count=%0d, expected no beat",
                         A, out_last, count);
            end else begin
                mon_e = exp_q.pop_front();
                if (A !== mon_e.a || out_last !== mon_e.last || count !== mon_e.cnt) begin
                    failures++;
                    $display("FAIL beat got A=%0d last=%0b count=%0d expected A=%0d last=%0b count=%0d",
                             A, out_last, count, mon_e.a, mon_e.last, mon_e.cnt);
                end
            end
        end
    end

    // Reference: list the set bits from the lowest up, mark the highest one,
    // and attach the popcount to every beat.
    task automatic push_expected(input logic [15:0] z);
        int   n;
        int   seen;
        beat_t b;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(z[i]);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (z[i]) begin
                seen++;
                b.a    = 4'(i);
                b.last = (seen == n);
                b.cnt  = 5'(n);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present z when in_ready is high. Return at posedge+1 of the cycle that
    // follows the handshake, with in_valid already dropped.
    task automatic send(input logic [15:0] z, input bit push_exp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%0b expected 1", in_ready);
        end
        Z        = z;
        in_valid = 1'b1;
        if (push_exp) push_expected(z);
        tick();
        in_valid = 1'b0;
    endtask

    // Count the cycles in which in_ready stays low, starting now.
    task automatic busy_cycles(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || !in_ready) begin
            failures++;
            $display("FAIL %s_drain pending=%0d in_ready=%0b expected 0 and 1",
                     name, exp_q.size(), in_ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        Z         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, A, out_last, count, zero_drop} !== 13'b0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b A=%0d last=%0b cnt=%0d zd=%0b expected all 0",
                     in_ready, out_valid, A, out_last, count, zero_drop);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] z;
        out_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            z = 16'h0001 << a;   // the 4-to-16 decoder function
            send(z, 1'b1);
            wait_idle("round_trip");
        end
    endtask

    task automatic test_two_bits();
        int n;
        out_ready = 1'b1;
        send(16'h8001, 1'b1);
        busy_cycles(n);
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL two_bits_busy got %0d cycles expected 2", n);
        end
        wait_idle("two_bits");
    endtask

    task automatic test_full();
        int n;
        out_ready = 1'b1;
        send(16'hFFFF, 1'b1);
        busy_cycles(n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL full_busy got %0d cycles expected 16", n);
        end
        wait_idle("full");
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send(16'h0124, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || A !== 4'd2 || out_last !== 1'b0 || count !== 5'd3) begin
                failures++;
                $display("FAIL backpressure_hold%0d got vld=%0b A=%0d last=%0b cnt=%0d expected 1 2 0 3",
                         i, out_valid, A, out_last, count);
            end
            // A bitmap offered during DRAIN must be ignored.
            Z        = 16'hFFFF;
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        busy_cycles(n);
        in_valid = 1'b0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL backpressure_busy got %0d cycles expected 3", n);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_ignored_input got vld=%0b pending=%0d expected 0 0",
                     out_valid, exp_q.size());
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(16'h0000, 1'b0);
        checks++;
        if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_pulse got zd=%0b vld=%0b rdy=%0b expected 1 0 1",
                     zero_drop, out_valid, in_ready);
        end
        tick();
        checks++;
        if (zero_drop !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_after got zd=%0b vld=%0b expected 0 0", zero_drop, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        beat_t b;
        out_ready = 1'b1;
        b.cnt  = 5'd8;
        b.last = 1'b0;
        b.a    = 4'd4;
        exp_q.push_back(b);
        b.a    = 4'd5;
        exp_q.push_back(b);
        send(16'hF0F0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, A, out_last, count, zero_drop} !== 13'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rdy=%0b vld=%0b A=%0d last=%0b cnt=%0d zd=%0b expected all 0",
                     in_ready, out_valid, A, out_last, count, zero_drop);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_beats got %0d pending expected 0", exp_q.size());
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release got rdy=%0b vld=%0b expected 1 0", in_ready, out_valid);
        end
        send(16'h0002, 1'b1);
        wait_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_two_bits();
        test_full();
        test_backpressure();
        test_zero();
        test_reset_mid_drain();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
